// File: rtl/elder_care_pkg.sv
// Shared constants and types for the elder-care sensing blocks.
//   CLOCKS_PER_SECOND    : system clock rate (1 MHz)
//   PULSE_COUNT_W        : width of the per-window beat count
//   PULSE_WINDOW_SECONDS : beat counting window length
//   BPM_SCALE            : bpm = count * BPM_SCALE (60 s / 10 s window)
//   qual_state_t         : beat qualifier FSM states
package elder_care_pkg;

  localparam int CLOCKS_PER_SECOND    = 1_000_000;
  localparam int PULSE_COUNT_W        = 8;
  localparam int PULSE_WINDOW_SECONDS = 10;
  localparam int BPM_SCALE            = 6;

  typedef enum logic {
    ARMED   = 1'b0,
    REFRACT = 1'b1
  } qual_state_t;

  // Increment that sticks at all-ones.
  function automatic logic [PULSE_COUNT_W-1:0] sat_inc(input logic [PULSE_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pulse_edge_qualifier.sv
// Conditions the raw pulse line and qualifies beats.
//   clk, reset : system clock, async active-high reset
//   enable     : low forces the qualifier ARMED and suppresses beats
//   pulse_in   : raw sensor pulse, asynchronous to clk
//   beat       : one-cycle pulse for each accepted rising edge
// Two-flop synchronizer, previous-value flop for edge detect, then a
// refractory FSM that blocks re-triggers for REFRACTORY_CYCLES clocks.
module pulse_edge_qualifier
  import elder_care_pkg::*;
#(
  parameter int REFRACTORY_CYCLES = 250_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic pulse_in,
  output logic beat
);

  localparam int RW = (REFRACTORY_CYCLES > 1) ? $clog2(REFRACTORY_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LOAD = RW'(REFRACTORY_CYCLES - 1);

  logic          s1, s2, s3;
  qual_state_t   state;
  logic [RW-1:0] ref_tmr;
  logic          rise, armed;

  assign rise  = s2 & ~s3;
  // The last refractory cycle (timer at 0) already accepts a new edge, so
  // beats exactly REFRACTORY_CYCLES apart both count.
  assign armed = (state == ARMED) || (ref_tmr == '0);
  assign beat  = enable & rise & armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      state   <= ARMED;
      ref_tmr <= '0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
      if (!enable) begin
        state   <= ARMED;
        ref_tmr <= '0;
      end else if (beat) begin
        state   <= REFRACT;
        ref_tmr <= REF_LOAD;
      end else if (state == REFRACT) begin
        if (ref_tmr == '0) state <= ARMED;
        else               ref_tmr <= ref_tmr - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_window_counter.sv
// Counts qualified heart beats over a fixed window and reports the count.
//   clk, reset     : system clock, async active-high reset
//   enable         : low idles the block and discards the running window
//   pulse_in       : raw sensor pulse, asynchronous to clk
//   pulse_count    : beats in the last completed window (saturates at 255)
//   count_valid    : one-cycle strobe when pulse_count updates
//   pulse_overflow : last completed window saturated
module pulse_window_counter
  import elder_care_pkg::*;
#(
  parameter int CLOCKS_PER_WINDOW = CLOCKS_PER_SECOND * PULSE_WINDOW_SECONDS,
  parameter int REFRACTORY_CYCLES = 250_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     pulse_in,
  output logic [PULSE_COUNT_W-1:0] pulse_count,
  output logic                     count_valid,
  output logic                     pulse_overflow
);

  localparam int TW = $clog2(CLOCKS_PER_WINDOW);
  localparam logic [TW-1:0] WIN_LAST = TW'(CLOCKS_PER_WINDOW - 1);

  logic                     beat;
  logic [TW-1:0]            win_tmr;
  logic [PULSE_COUNT_W-1:0] run_cnt, cnt_next;
  logic                     run_ovf, ovf_next, terminal;

  pulse_edge_qualifier #(
    .REFRACTORY_CYCLES(REFRACTORY_CYCLES)
  ) u_qual (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .pulse_in(pulse_in),
    .beat    (beat)
  );

  // Next-count values fold in a beat from the current cycle, so a beat on
  // the terminal cycle lands in the window being closed.
  assign terminal = (win_tmr == WIN_LAST);
  assign cnt_next = beat ? sat_inc(run_cnt) : run_cnt;
  assign ovf_next = run_ovf | (beat & (&run_cnt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_tmr        <= '0;
      run_cnt        <= '0;
      run_ovf        <= 1'b0;
      pulse_count    <= '0;
      count_valid    <= 1'b0;
      pulse_overflow <= 1'b0;
    end else if (!enable) begin
      win_tmr     <= '0;
      run_cnt     <= '0;
      run_ovf     <= 1'b0;
      count_valid <= 1'b0;
    end else if (terminal) begin
      win_tmr        <= '0;
      run_cnt        <= '0;
      run_ovf        <= 1'b0;
      pulse_count    <= cnt_next;
      pulse_overflow <= ovf_next;
      count_valid    <= 1'b1;
    end else begin
      win_tmr     <= win_tmr + 1'b1;
      run_cnt     <= cnt_next;
      run_ovf     <= ovf_next;
      count_valid <= 1'b0;
    end
  end

endmodule
